// File: rtl/threat_monitor.sv
// Debounced eight-criterion threat classifier with per-bit persistence/release hysteresis.
// Optional sticky status is built only when THREAT_MON_STICKY_EN is defined.
module threat_monitor #(
  parameter int DATA_W    = 8,
  parameter int PERSIST_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_valid,
  input  logic [DATA_W-1:0]    signal_in,
  input  logic [DATA_W-1:0]    hi_thresh,
  input  logic [DATA_W-1:0]    lo_thresh,
  input  logic [DATA_W-1:0]    spoof_sig,
  input  logic [PERSIST_W-1:0] persist_thr,
  input  logic [PERSIST_W-1:0] release_thr,
  input  logic                 sticky_clr,
  output logic [7:0]           threat_vector,
  output logic                 threat_change,
  output logic [CNT_W-1:0]     threat_count,
  output logic [7:0]           threat_sticky
);

  logic [DATA_W-1:0]    prev_q, prev_d;
  logic                 prev_ok_q, prev_ok_d;
  logic [7:0]           vec_q, vec_d;
  logic [PERSIST_W-1:0] cnt_q [8];
  logic [PERSIST_W-1:0] cnt_d [8];
  logic                 flip_q, flip_d;
  logic                 change_q;
  logic [CNT_W-1:0]     count_q, count_d, count_base;

  logic [7:0]           raw;
  logic [7:0]           rise;
  logic [DATA_W-1:0]    ramp_val;
  logic [PERSIST_W-1:0] persist_eff, release_eff, thr;
  logic [PERSIST_W:0]   cnt_inc;

  assign ramp_val    = prev_q + DATA_W'(1);
  assign persist_eff = (persist_thr == '0) ? PERSIST_W'(1) : persist_thr;
  assign release_eff = (release_thr == '0) ? PERSIST_W'(1) : release_thr;

  // Raw criteria; history-based bits stay quiet until a first sample exists.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    raw    = '0;
    raw[0] = signal_in > hi_thresh;
    raw[1] = signal_in < lo_thresh;
    raw[2] = signal_in == spoof_sig;
    raw[3] = signal_in == '0;
    raw[4] = prev_ok_q && (signal_in == ramp_val);
    raw[5] = signal_in == '1;
    raw[6] = ^signal_in;
    raw[7] = prev_ok_q && (signal_in == prev_q);
  end

  always_comb begin
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    thr       = '0;
    cnt_inc   = '0;
    if (sample_valid) begin
      prev_d    = signal_in;
      prev_ok_d = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (raw[i] == vec_q[i]) begin
          cnt_d[i] = '0;
        end else begin
          thr     = vec_q[i] ? release_eff : persist_eff;
          cnt_inc = {1'b0, cnt_q[i]} + (PERSIST_W+1)'(1);
          if (cnt_inc >= {1'b0, thr}) begin
            vec_d[i] = ~vec_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_inc[PERSIST_W-1:0];
          end
        end
      end
    end
  end

  assign rise   = vec_d & ~vec_q;
  assign flip_d = |(vec_d ^ vec_q);

  // Clear takes effect before the increment, so a coinciding onset leaves a count of 1.
  always_comb begin
    count_base = sticky_clr ? '0 : count_q;
    count_d    = count_base;
    if (|rise && !(&count_base)) count_d = count_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      vec_q     <= '0;
      flip_q    <= 1'b0;
      change_q  <= 1'b0;
      count_q   <= '0;
      // NOTE: the qualifier counters are ordinary flops, so they are reset to drop partial runs.
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      vec_q     <= vec_d;
      flip_q    <= flip_d;
      change_q  <= flip_q;
      count_q   <= count_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef THREAT_MON_STICKY_EN
  logic [7:0] sticky_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sticky_q <= '0;
    else          sticky_q <= (sticky_clr ? 8'h00 : sticky_q) | vec_q;
  end

  assign threat_sticky = sticky_q;
`else
  assign threat_sticky = '0;
`endif

  assign threat_vector = vec_q;
  assign threat_change = change_q;
  assign threat_count  = count_q;

endmodule

// File: tb/tb_threat_monitor.sv
// Scoreboard bench for threat_monitor: directed scenarios then randomized traffic against a rule-level model.
module tb_threat_monitor;
  localparam int DATA_W    = 8;
  localparam int PERSIST_W = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 sample_valid;
  logic [DATA_W-1:0]    signal_in, hi_thresh, lo_thresh, spoof_sig;
  logic [PERSIST_W-1:0] persist_thr, release_thr;
  logic                 sticky_clr;
  logic [7:0]           threat_vector;
  logic                 threat_change;
  logic [CNT_W-1:0]     threat_count;
  logic [7:0]           threat_sticky;

  always #5 clk = ~clk;

  threat_monitor #(.DATA_W(DATA_W), .PERSIST_W(PERSIST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .signal_in(signal_in),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .spoof_sig(spoof_sig),
    .persist_thr(persist_thr), .release_thr(release_thr), .sticky_clr(sticky_clr),
    .threat_vector(threat_vector), .threat_change(threat_change),
    .threat_count(threat_count), .threat_sticky(threat_sticky)
  );

  typedef struct {
    int vec;
    int chg;
    int cnt;
    int sticky;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Configuration applied to the ports on the next stimulus cycle.
  int m_hi = 255, m_lo = 0, m_spoof = 170, m_p = 1, m_r = 1;

  // Reference model state: per-criterion flag plus length of the current disagreeing run.
  int st[8], run[8];
  int prev = 0, prev_ok = 0, mcnt = 0, msticky = 0, flip_prev = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int vec_of();
    int v = 0;
    for (int i = 0; i < 8; i++) v |= st[i] << i;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin st[i] = 0; run[i] = 0; end
    prev = 0; prev_ok = 0; mcnt = 0; msticky = 0; flip_prev = 0;
  endtask

  task automatic model_step(input bit v, input int x, input bit clr, output exp_t e);
    int old_vec = vec_of();
    int raw[8];
    int t;
    bit flipped = 0, rose = 0;
    if (v) begin
      raw[0] = x > m_hi;
      raw[1] = x < m_lo;
      raw[2] = x == m_spoof;
      raw[3] = x == 0;
      raw[4] = prev_ok && (x == (prev + 1) % 256);
      raw[5] = x == 255;
      raw[6] = $countones(x) % 2;
      raw[7] = prev_ok && (x == prev);
      for (int i = 0; i < 8; i++) begin
        if (raw[i] == st[i]) run[i] = 0;
        else begin
          t = st[i] ? m_r : m_p;
          if (t == 0) t = 1;
          run[i]++;
          if (run[i] >= t) begin
            st[i] = 1 - st[i];
            run[i] = 0;
            flipped = 1;
            if (st[i] == 1) rose = 1;
          end
        end
      end
      prev = x; prev_ok = 1;
    end
`ifdef THREAT_MON_STICKY_EN
    msticky = (clr ? 0 : msticky) | old_vec;
`else
    msticky = 0;
`endif
    if (clr) mcnt = 0;
    if (rose && mcnt < CNT_MAX) mcnt++;
    e.vec = vec_of();
    e.chg = flip_prev;
    e.cnt = mcnt;
    e.sticky = msticky;
    flip_prev = flipped;
  endtask

  // Drive one clock's worth of inputs and queue the state expected after that edge.
  task automatic cycle(input bit v, input int x, input bit clr = 0);
    exp_t e;
    @(negedge clk);
    sample_valid = v;
    signal_in    = x[7:0];
    sticky_clr   = clr;
    hi_thresh    = m_hi[7:0];
    lo_thresh    = m_lo[7:0];
    spoof_sig    = m_spoof[7:0];
    persist_thr  = m_p[3:0];
    release_thr  = m_r[3:0];
    model_step(v, x, clr, e);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; sample_valid = 1'b0; sticky_clr = 1'b0;
    #1;
    check("reset_vector", int'(threat_vector), 0);
    check("reset_change", int'(threat_change), 0);
    check("reset_count", int'(threat_count), 0);
    check("reset_sticky", int'(threat_sticky), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("threat_vector", int'(threat_vector), mon_e.vec);
      check("threat_change", int'(threat_change), mon_e.chg);
      check("threat_count", int'(threat_count), mon_e.cnt);
      check("threat_sticky", int'(threat_sticky), mon_e.sticky);
    end
  end

  initial begin
    int x, pick, budget;
    reset_n = 1'b0; sample_valid = 1'b0; signal_in = '0; sticky_clr = 1'b0;
    hi_thresh = '0; lo_thresh = '0; spoof_sig = '0; persist_thr = '0; release_thr = '0;
    model_reset();
    #12;
    check("por_vector", int'(threat_vector), 0);
    check("por_count", int'(threat_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // First sample after reset: only the drop criterion fires.
    m_hi = 255; m_lo = 10; m_spoof = 170; m_p = 1; m_r = 1;
    cycle(1, 5); cycle(0, 0); cycle(0, 0);

    // Persistence of three; idle does not break a run, a clean sample restarts it.
    do_reset();
    m_lo = 0; m_hi = 200; m_p = 3; m_r = 2;
    cycle(1, 210); cycle(1, 210); cycle(0, 0); cycle(1, 210); cycle(0, 0);
    // Release hysteresis of two, interrupted once.
    cycle(1, 50); cycle(1, 210); cycle(1, 50); cycle(1, 50); cycle(0, 0);
    do_reset();
    cycle(1, 210); cycle(1, 210); cycle(1, 50); cycle(1, 210); cycle(0, 0);

    // Ramp, saturation and stuck across the wrap point.
    do_reset();
    m_p = 1; m_r = 1; m_hi = 255; m_lo = 0;
    cycle(1, 254); cycle(1, 255); cycle(1, 0); cycle(1, 0); cycle(0, 0);

    // Counter saturation, then clear coinciding with a new onset.
    do_reset();
    m_spoof = 123;
    for (int k = 0; k < 5; k++) begin cycle(1, 123); cycle(1, 80); cycle(1, 81); end
    cycle(1, 123, 1); cycle(0, 0); cycle(0, 0);

    // Sticky accumulation and clear.
    do_reset();
    cycle(1, 123); cycle(1, 80); cycle(0, 0); cycle(0, 0); cycle(0, 0, 1); cycle(0, 0);

    // Randomized traffic including live threshold changes and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        m_hi = $urandom_range(0, 255); m_lo = $urandom_range(0, 255);
        m_spoof = $urandom_range(0, 255);
        m_p = $urandom_range(0, 4); m_r = $urandom_range(0, 4);
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      pick = $urandom_range(0, 7);
      case (pick)
        0: x = (m_hi + 1) % 256;
        1: x = (m_lo + 255) % 256;
        2: x = m_spoof;
        3: x = 0;
        4: x = (prev + 1) % 256;
        5: x = prev;
        6: x = 255;
        default: x = $urandom_range(0, 255);
      endcase
      cycle($urandom_range(0, 3) != 0, x, $urandom_range(0, 31) == 0);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
